// File: rtl/pulse_period_meter.sv
// Measures the spacing between rising edges of an asynchronous pulse train in
// enabled clock cycles and presents each interval through a valid/ready register.
module pulse_period_meter #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         overflow,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    SAT     = 2'd2
  } state_e;

  localparam logic [N-1:0] CNT_MAX = '1;

  // Input synchronizer and edge detector
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   delay_q, delay_d;
  logic                   rise;

  // Interval measurement
  state_e                 state_q, state_d;
  logic [N-1:0]           cnt_q, cnt_d;
  logic                   capture;
  logic [N-1:0]           cap_period;
  logic                   cap_ovf;

  // Output register
  logic [N-1:0]           period_q, period_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic                   missed_q, missed_d;
  logic                   accept;

  // Edge detection runs every cycle regardless of ena, so no edge is lost
  // while the counter is frozen.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pulse_in};
    delay_d = sync_q[SYNC_STAGES-1];
    rise    = sync_q[SYNC_STAGES-1] & ~delay_q;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    cap_period = cnt_q;
    cap_ovf    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (rise) begin
          capture    = 1'b1;
          cap_period = cnt_q;
          cnt_d      = '0;
        end else if (ena) begin
          if (cnt_q == CNT_MAX) begin
            state_d = SAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      SAT: begin
        cnt_d = CNT_MAX;
        if (rise) begin
          capture    = 1'b1;
          cap_period = CNT_MAX;
          cap_ovf    = 1'b1;
          cnt_d      = '0;
          state_d    = MEASURE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A capture while the held result is unconsumed is dropped and flagged;
  // an accept in the same cycle frees the slot for the new result.
  always_comb begin
    accept     = valid_q & period_ready;
    period_d   = period_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    missed_d   = missed_q;

    if (capture) begin
      if (!valid_q || period_ready) begin
        period_d   = cap_period;
        overflow_d = cap_ovf;
        valid_d    = 1'b1;
      end else begin
        missed_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      missed_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      delay_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      delay_q    <= delay_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      missed_q   <= missed_d;
    end
  end

  assign period       = period_q;
  assign overflow     = overflow_q;
  assign period_valid = valid_q;
  assign missed       = missed_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed scenarios plus random pulse trains,
// compared every cycle against an interval-counting reference model.
module tb_pulse_period_meter;

  localparam int N    = 8;
  localparam int S    = 2;
  localparam int FULL = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic         pulse_in = 1'b0;
  logic         period_ready = 1'b0;
  logic [N-1:0] period;
  logic         overflow;
  logic         period_valid;
  logic         missed;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edges are recognised S edges after first being sampled
  // high; an interval is the number of enabled cycles strictly between two
  // recognised edges, saturating at FULL-1 with overflow once it reaches FULL.
  bit           hist[$];
  bit           m_seen;
  int           m_cnt;
  logic [N-1:0] m_period;
  logic         m_ovf;
  logic         m_valid;
  logic         m_missed;

  pulse_period_meter #(.N(N), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .pulse_in     (pulse_in),
    .period       (period),
    .overflow     (overflow),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .missed       (missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 1; i++) hist.push_back(1'b0);
    m_seen   = 1'b0;
    m_cnt    = 0;
    m_period = '0;
    m_ovf    = 1'b0;
    m_valid  = 1'b0;
    m_missed = 1'b0;
  endtask

  task automatic model_edge(input bit p, input bit en, input bit rdy);
    bit           rise;
    bit           cap;
    bit           acc;
    int           cv;
    logic [N-1:0] cap_p;
    logic         cap_o;
    hist.push_back(p);
    if (hist.size() > S + 2) void'(hist.pop_front());
    rise  = hist[1] && !hist[0];
    cap   = 1'b0;
    cap_p = '0;
    cap_o = 1'b0;
    if (rise) begin
      if (m_seen) begin
        cap   = 1'b1;
        cap_o = (m_cnt >= FULL);
        cv    = cap_o ? FULL - 1 : m_cnt;
        cap_p = cv[N-1:0];
      end
      m_seen = 1'b1;
      m_cnt  = 0;
    end else if (m_seen && en) begin
      m_cnt++;
    end
    acc = m_valid && rdy;
    if (cap) begin
      if (!m_valid || rdy) begin
        m_period = cap_p;
        m_ovf    = cap_o;
        m_valid  = 1'b1;
      end else begin
        m_missed = 1'b1;
      end
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (acc) m_missed = 1'b0;
  endtask

  task automatic check_model();
    chk("period", period, m_period);
    chk("overflow", overflow, m_ovf);
    chk("period_valid", period_valid, m_valid);
    chk("missed", missed, m_missed);
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, check
  // at the following negedge.
  task automatic step(input bit p, input bit en, input bit rdy);
    pulse_in     = p;
    ena          = en;
    period_ready = rdy;
    @(posedge clk);
    model_edge(p, en, rdy);
    @(negedge clk);
    check_model();
  endtask

  // ena_mode: 0 always on, 1 on at even offsets, 2 off, 3 random.
  // rdy_mode: 0 ready, 1 not ready, 2 random.
  task automatic train(input int spacing, input int width, input int count,
                       input int ena_mode, input int rdy_mode);
    bit en;
    bit rdy;
    for (int c = 0; c < count; c++) begin
      for (int i = 0; i < spacing; i++) begin
        case (ena_mode)
          0:       en = 1'b1;
          1:       en = (i % 2) == 0;
          2:       en = 1'b0;
          default: en = ($urandom_range(3) != 0);
        endcase
        case (rdy_mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'b0;
          default: rdy = $urandom_range(1) == 1;
        endcase
        step(i < width, en, rdy);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_valid"}, period_valid, 0);
    chk({tag, "_missed"}, missed, 0);
  endtask

  initial begin
    int sp;
    int w;
    model_reset();

    // Reset state, visible before any clock edge
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Test 1: 11-cycle spacing reports 10; first edge produces nothing
    train(11, 1, 1, 0, 0);
    chk("t1_first_no_valid", period_valid, 0);
    train(11, 1, 5, 0, 0);
    chk("t1_period", period, 10);
    chk("t1_overflow", overflow, 0);

    // Test 2: saturation, then recovery
    train(300, 1, 2, 0, 0);
    chk("t2_sat_period", period, 255);
    chk("t2_sat_overflow", overflow, 1);
    train(11, 1, 2, 0, 0);
    chk("t2_recover_period", period, 10);
    chk("t2_recover_overflow", overflow, 0);

    // Saturation boundary: 255 counts fits, 256 counts overflows
    train(256, 1, 2, 0, 0);
    chk("bnd_255_period", period, 255);
    chk("bnd_255_overflow", overflow, 0);
    train(257, 1, 2, 0, 0);
    chk("bnd_256_period", period, 255);
    chk("bnd_256_overflow", overflow, 1);
    train(11, 1, 1, 0, 0);

    // Test 3: unconsumed results are dropped and flagged
    train(11, 1, 3, 0, 1);
    chk("t3_valid_held", period_valid, 1);
    chk("t3_period_held", period, 10);
    chk("t3_missed", missed, 1);
    step(1'b0, 1'b1, 1'b1);
    chk("t3_accept_valid", period_valid, 0);
    chk("t3_accept_missed", missed, 0);

    // Test 4: half-rate enable, then enable held low
    train(20, 1, 4, 1, 0);
    chk("t4_half_rate_period", period, 9);
    train(20, 1, 3, 2, 0);
    chk("t4_frozen_period", period, 0);

    // Test 5: long high levels give one capture each
    train(100, 50, 3, 0, 0);
    chk("t5_level_period", period, 99);
    chk("t5_level_overflow", overflow, 0);

    // Test 6: asynchronous reset in MEASURE with a held result
    train(11, 1, 2, 0, 1);
    chk("t6_pre_valid", period_valid, 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    train(11, 1, 1, 0, 1);
    chk("t6_first_no_valid", period_valid, 0);
    train(11, 1, 1, 0, 1);
    chk("t6_second_valid", period_valid, 1);
    chk("t6_second_period", period, 10);
    chk("t6_second_missed", missed, 0);

    // Random pulse trains with random enable and ready
    for (int r = 0; r < 25; r++) begin
      sp = $urandom_range(320, 2);
      w  = $urandom_range(sp - 1, 1);
      train(sp, w, 1, 3, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
